piso_unloader: RTL and testbench
================================

// Module: piso_unloader
// PURPOSE
//   Transmit side of the 4-bit parallel-load register path.
//   - Captures a parallel word D on a start command.
//   - Serialises the word one bit per clock on sdo, with valid and framing strobes.
//   - Sits downstream of a parallel-load register and drives a serial link.
//   - Uses the same PE-style 2-bit command encoding as the load-register family.
// PARAMETERS
//   WIDTH      4   word width in bits, >= 2
//   MSB_FIRST  0   0: D[0] is shifted out first; 1: D[WIDTH-1] is shifted out first
// PORTS
//   clk        in   1      single clock; all logic on the rising edge
//   r          in   1      reset, synchronous, active-high
//   PE         in   2      command: 11 start, 10 pause, 01 abort, 00 none
//   D          in   WIDTH  parallel word; sampled only when a start is accepted
//   sdo        out  1      serial data out
//   sdo_valid  out  1      sdo carries a payload bit this cycle
//   first      out  1      high with the first payload bit of a word
//   last       out  1      high with the final payload bit of a word
//   busy       out  1      word in flight (SHIFT or PAUSE state)
//   done       out  1      1-cycle pulse: word fully sent
//   aborted    out  1      1-cycle pulse: word dropped by an abort
// BEHAVIOUR
//   Reset and encoding
//   - Reset (r=1 at a clock edge) forces state IDLE and clears shreg and cnt.
//   - Reset drives sdo, sdo_valid, first, last, busy, done and aborted to 0.
//   - Reset overrides any PE command in the same cycle and clears a word mid-frame.
//   - Register all outputs; no combinational path from PE or D to any output.
//   - State encoding: IDLE, SHIFT, PAUSE.
//   IDLE
//   - PE=11: load shreg<=D, set cnt<=0, go to SHIFT.
//   - PE=10 or 01: ignored.
//   SHIFT
//   - Each cycle, present the next bit as sdo with sdo_valid=1, then increment cnt.
//   - first=1 when cnt==0; last=1 when cnt==WIDTH-1.
//   - After the bit at cnt==WIDTH-1: go to IDLE and pulse done next cycle.
//   PAUSE
//   - PE=10 during SHIFT: go to PAUSE. No bit is emitted that cycle (sdo_valid=0).
//   - cnt and shreg hold; sdo keeps its last value.
//   - Any PE other than 10 resumes SHIFT from the held bit position.
//   Abort
//   - PE=01 in SHIFT or PAUSE: go to IDLE, pulse aborted next cycle, no done pulse.
//   - The bit scheduled in the abort cycle is not emitted.
//   Start handling and precedence
//   - PE=11 in SHIFT or PAUSE is ignored; the in-flight word is never overwritten.
//   - Precedence in SHIFT and PAUSE: reset > abort(01) > pause(10).
//   Timing
//   - Start accepted at edge N: payload bits are valid at cycles N+1 .. N+WIDTH.
//   - A pause adds exactly one cycle per paused cycle.
//   - done is high in cycle N+WIDTH+1, with busy=0 and state IDLE.
//   - A start in that same cycle is accepted: back-to-back words, one idle cycle between frames.
//   Sizing and width rules
//   - cnt width is $clog2(WIDTH); cnt never wraps past WIDTH-1.
//   - Shift direction is set by MSB_FIRST; shreg is WIDTH bits wide; vacated bits fill with 0.
// TESTING
//   1 reset: r=1 for 2 cycles with PE=11 -> all outputs 0, state IDLE, no word started
//   2 LSB-first frame (WIDTH=4): D=4'b1011, PE=11 one cycle ->
//     sdo=1,1,0,1 at N+1..N+4; first at N+1; last at N+4; done at N+5
//   3 MSB_FIRST=1, D=4'b1011 -> sdo=1,0,1,1; busy high N+1..N+4
//   4 pause: PE=10 during the 2nd bit for 2 cycles ->
//     sdo_valid=0 for 2 cycles; sequence resumes intact; done at N+7
//   5 abort: PE=01 during the 3rd bit -> aborted pulse, no done, no further sdo_valid; next start sends a fresh word
//   6 back-to-back and overlap:
//     PE=11 in the done cycle with D=4'b0110 -> second frame starts at once;
//     PE=11 mid-frame -> ignored, first word completes unchanged

Source files
------------

// File: rtl/piso_unloader.sv
// piso_unloader: transmit side of the parallel-load register path.
//
// A start command captures a parallel word. The word then leaves one bit per clock on sdo,
// with valid and first/last framing strobes. The command encoding is the 2-bit PE code of the
// load-register family: 11 start, 10 pause, 01 abort, 00 none.
//
// Ports
//   clk_i         clock; all logic on the rising edge
//   r_i           synchronous active-high reset
//   pe_i          2-bit command
//   d_i           parallel word, sampled only when a start is accepted
//   sdo_o         serial data out
//   sdo_valid_o   sdo_o carries a payload bit this cycle
//   first_o       high with the first payload bit of a word
//   last_o        high with the final payload bit of a word
//   busy_o        a word is in flight (shifting or paused)
//   done_o        1-cycle pulse after the final bit of a word
//   aborted_o     1-cycle pulse after a word is dropped by an abort
//
// Every output is a flop. Its next value is derived from the next state, so a start accepted
// at one edge shows the first bit straight after that edge. A start issued in the done cycle
// therefore leaves exactly one idle cycle between frames.

module piso_unloader #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             r_i,
  input  logic [1:0]       pe_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             sdo_o,
  output logic             sdo_valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  localparam logic [1:0] CmdStart = 2'b11;
  localparam logic [1:0] CmdPause = 2'b10;
  localparam logic [1:0] CmdAbort = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StPause
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic sdo_q, sdo_d;
  logic sdo_valid_q, sdo_valid_d;
  logic first_q, first_d;
  logic last_q, last_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic aborted_q, aborted_d;

  // shreg always holds the bit currently on show (or about to be) at its head end.
  logic [WIDTH-1:0] shreg_adv;
  logic             head_bit;

  always_comb begin
    shreg_adv = '0;
    if (MSB_FIRST) begin
      shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // Next-state logic. In SHIFT the bit on show this cycle is consumed at the coming edge
  // unless an abort drops it. A pause still consumes it, and the following bit waits in PAUSE.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      StIdle: begin
        // Pause and abort have no meaning without a word in flight.
        if (pe_i == CmdStart) begin
          shreg_d = d_i;
          cnt_d   = '0;
          state_d = StShift;
        end
      end

      StShift: begin
        if (pe_i == CmdAbort) begin
          shreg_d   = '0;
          cnt_d     = '0;
          aborted_d = 1'b1;
          state_d   = StIdle;
        end else begin
          shreg_d = shreg_adv;
          if (cnt_q == CntMax) begin
            // The final bit just went out; a pause here has nothing left to hold.
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
            if (pe_i == CmdPause) begin
              state_d = StPause;
            end
          end
        end
      end

      StPause: begin
        if (pe_i == CmdAbort) begin
          shreg_d   = '0;
          cnt_d     = '0;
          aborted_d = 1'b1;
          state_d   = StIdle;
        end else if (pe_i != CmdPause) begin
          // Start is ignored mid-word, so it resumes just like "none".
          state_d = StShift;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output next values, taken from the state the machine is about to enter.
  always_comb begin
    head_bit    = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
    sdo_valid_d = (state_d == StShift);
    // sdo holds its last value whenever no bit is on show.
    sdo_d       = sdo_valid_d ? head_bit : sdo_q;
    first_d     = sdo_valid_d && (cnt_d == '0);
    last_d      = sdo_valid_d && (cnt_d == CntMax);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (r_i) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      cnt_q       <= '0;
      sdo_q       <= 1'b0;
      sdo_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      sdo_q       <= sdo_d;
      sdo_valid_q <= sdo_valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign sdo_o       = sdo_q;
  assign sdo_valid_o = sdo_valid_q;
  assign first_o     = first_q;
  assign last_o      = last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_piso_unloader.sv
// Bench for piso_unloader. Two instances share one stimulus: index 0 is LSB-first, index 1 is
// MSB-first. A word/index model predicts every output cycle, and a compare process checks it
// on each falling edge. Literal expectations taken from the frame captures pin down the model.
// Cycle numbering: "cycle k" follows clock edge k; a command presented in cycle n is accepted
// at edge n+1, so its first bit shows in cycle n+1.

module tb_piso_unloader;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       r;
  logic [1:0] pe;
  logic [3:0] d;

  logic [1:0] sdo_w, val_w, first_w, last_w, busy_w, done_w, abort_w;

  piso_unloader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .r_i(r), .pe_i(pe), .d_i(d),
    .sdo_o(sdo_w[0]), .sdo_valid_o(val_w[0]), .first_o(first_w[0]), .last_o(last_w[0]),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .aborted_o(abort_w[0])
  );

  piso_unloader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .r_i(r), .pe_i(pe), .d_i(d),
    .sdo_o(sdo_w[1]), .sdo_valid_o(val_w[1]), .first_o(first_w[1]), .last_o(last_w[1]),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .aborted_o(abort_w[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: word in flight, index of the bit on show (or next to show), whether it is on show.
  bit         mf[2];
  bit         ms[2];
  int         mk[2];
  logic [3:0] mw[2];
  bit         e_done[2];
  bit         e_abort[2];
  bit         mdl_ok = 1'b0;

  // Captures of what the DUTs actually emitted, for the literal checks.
  logic [15:0] cap[2];
  int          cap_n[2];
  int          busy_n[2];
  int          done_cnt[2];
  int          done_cyc[2];
  int          first_cyc[2];
  int          last_cyc[2];
  int          abort_cyc[2];

  task automatic chk(input string nm, input int m, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, m, cyc, act, exp);
    end
  endtask

  function automatic logic bit_of(input int m, input logic [3:0] w, input int k);
    return (m == 1) ? w[W-1-k] : w[k];
  endfunction

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      e_done[m]  = 1'b0;
      e_abort[m] = 1'b0;
      if (r) begin
        mf[m] = 1'b0;
        ms[m] = 1'b0;
        mk[m] = 0;
      end else if (!mf[m]) begin
        if (pe == 2'b11) begin
          mf[m] = 1'b1;
          mw[m] = d;
          mk[m] = 0;
          ms[m] = 1'b1;
        end
      end else if (pe == 2'b01) begin
        mf[m]      = 1'b0;
        ms[m]      = 1'b0;
        e_abort[m] = 1'b1;
      end else if (ms[m]) begin
        if (mk[m] == W - 1) begin
          mf[m]     = 1'b0;
          ms[m]     = 1'b0;
          e_done[m] = 1'b1;
        end else begin
          mk[m]++;
          ms[m] = (pe != 2'b10);
        end
      end else if (pe != 2'b10) begin
        ms[m] = 1'b1;
      end
    end
    if (r) mdl_ok = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mdl_ok) begin
        for (int m = 0; m < 2; m++) begin
          chk("sdo_valid", m, 32'(val_w[m]), 32'(ms[m]));
          chk("busy", m, 32'(busy_w[m]), 32'(mf[m]));
          chk("first", m, 32'(first_w[m]), 32'(ms[m] && mk[m] == 0));
          chk("last", m, 32'(last_w[m]), 32'(ms[m] && mk[m] == W - 1));
          chk("done", m, 32'(done_w[m]), 32'(e_done[m]));
          chk("aborted", m, 32'(abort_w[m]), 32'(e_abort[m]));
          if (ms[m]) chk("sdo", m, 32'(sdo_w[m]), 32'(bit_of(m, mw[m], mk[m])));

          if (val_w[m]) begin
            if (cap_n[m] < 16) cap[m][cap_n[m]] = sdo_w[m];
            cap_n[m]++;
          end
          if (busy_w[m]) busy_n[m]++;
          if (first_w[m]) first_cyc[m] = cyc;
          if (last_w[m]) last_cyc[m] = cyc;
          if (done_w[m]) begin
            done_cyc[m] = cyc;
            done_cnt[m]++;
          end
          if (abort_w[m]) abort_cyc[m] = cyc;
        end
      end
    end
  end

  task automatic tick(input logic rr, input logic [1:0] p, input logic [3:0] dd);
    r  = rr;
    pe = p;
    d  = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 4'hF);
  endtask

  task automatic clear_cap();
    for (int m = 0; m < 2; m++) begin
      cap[m]       = '0;
      cap_n[m]     = 0;
      busy_n[m]    = 0;
      done_cnt[m]  = 0;
      done_cyc[m]  = -1;
      first_cyc[m] = -1;
      last_cyc[m]  = -1;
      abort_cyc[m] = -1;
    end
  endtask

  int n;
  int n2;

  initial begin
    clear_cap();
    r  = 1'b1;
    pe = 2'b11;
    d  = 4'b1011;

    // 1: reset held two cycles with a start command present.
    tick(1'b1, 2'b11, 4'b1011);
    tick(1'b1, 2'b11, 4'b1011);
    @(negedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_sdo", m, 32'(sdo_w[m]), 32'd0);
      chk("rst_busy", m, 32'(busy_w[m]), 32'd0);
      chk("rst_valid", m, 32'(val_w[m]), 32'd0);
    end
    idle(3);
    @(negedge clk);
    #1;
    chk("rst_no_word", 0, 32'(cap_n[0]), 32'd0);

    // 2/3: D=1011; LSB-first sends 1,1,0,1 and MSB-first sends 1,0,1,1.
    clear_cap();
    n = cyc;
    tick(1'b0, 2'b11, 4'b1011);
    idle(4);
    @(negedge clk);
    #1;
    chk("lsb_bits", 0, 32'(cap[0][3:0]), 32'b1011);
    chk("msb_bits", 1, 32'(cap[1][3:0]), 32'b1101);
    chk("first_at", 0, 32'(first_cyc[0] - n), 32'd1);
    chk("last_at", 0, 32'(last_cyc[0] - n), 32'd4);
    chk("done_at", 0, 32'(done_cyc[0] - n), 32'd5);
    chk("busy_cycles", 1, 32'(busy_n[1]), 32'd4);

    // 4: pause during the 2nd bit for two cycles.
    clear_cap();
    n = cyc;
    tick(1'b0, 2'b11, 4'b1011);
    idle(1);
    tick(1'b0, 2'b10, 4'hF);
    tick(1'b0, 2'b10, 4'hF);
    idle(3);
    @(negedge clk);
    #1;
    chk("pause_bits", 0, 32'(cap[0][3:0]), 32'b1011);
    chk("pause_nbits", 0, 32'(cap_n[0]), 32'd4);
    chk("pause_done_at", 0, 32'(done_cyc[0] - n), 32'd7);
    chk("pause_busy", 0, 32'(busy_n[0]), 32'd6);

    // 5: abort during the 3rd bit, then a fresh word.
    clear_cap();
    n = cyc;
    tick(1'b0, 2'b11, 4'b1011);
    idle(2);
    tick(1'b0, 2'b01, 4'hF);
    idle(2);
    @(negedge clk);
    #1;
    chk("abort_nbits", 0, 32'(cap_n[0]), 32'd3);
    chk("abort_bits", 0, 32'(cap[0][2:0]), 32'b011);
    chk("abort_at", 0, 32'(abort_cyc[0] - n), 32'd4);
    chk("abort_no_done", 0, 32'(done_cnt[0]), 32'd0);
    clear_cap();
    n = cyc;
    tick(1'b0, 2'b11, 4'b0110);
    idle(4);
    @(negedge clk);
    #1;
    chk("fresh_lsb", 0, 32'(cap[0][3:0]), 32'b0110);
    chk("fresh_msb", 1, 32'(cap[1][3:0]), 32'b0110);
    chk("fresh_done_at", 1, 32'(done_cyc[1] - n), 32'd5);

    // 6: start in the done cycle, then a start mid-frame that must be ignored.
    clear_cap();
    n = cyc;
    tick(1'b0, 2'b11, 4'b1011);
    idle(4);
    n2 = cyc;
    tick(1'b0, 2'b11, 4'b0110);
    idle(1);
    tick(1'b0, 2'b11, 4'b1111);
    idle(2);
    @(negedge clk);
    #1;
    chk("b2b_lsb", 0, 32'(cap[0][7:0]), 32'b0110_1011);
    chk("b2b_msb", 1, 32'(cap[1][7:0]), 32'b0110_1101);
    chk("b2b_nbits", 0, 32'(cap_n[0]), 32'd8);
    chk("b2b_first_at", 0, 32'(first_cyc[0] - n2), 32'd1);
    chk("b2b_done_at", 0, 32'(done_cyc[0] - n2), 32'd5);
    chk("b2b_dones", 0, 32'(done_cnt[0]), 32'd2);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
